// File: rtl/gb_pkg.sv
// gb_pkg: shared ghostbus definitions.
// Holds the default bus widths, the default read latency (shared with the
// decoder generator) and the response entry layout carried from the bus
// capture point back to the command source.
package gb_pkg;

    localparam int GB_AW       = 24;
    localparam int GB_DW       = 32;
    localparam int GB_RD_LAT   = 1;
    localparam int GB_RF_DEPTH = 4;

    // One response: write completion (we=1, rdata=0) or read data (we=0).
    typedef struct packed {
        logic             we;
        logic [GB_DW-1:0] rdata;
    } gb_rsp_t;

endpackage

// File: rtl/gb_host_master_if.sv
// gb_host_master_if: command stream, response stream and root ghostbus
// signals of the host master, bundled for connection.
//   cmd_*  : valid/ready command stream (source -> master)
//   rsp_*  : valid/ready response stream (master -> source)
//   gb_*   : root bus toward the decoder tree (gb_din flows back)
// Modport master is the host master's view; slave is the surrounding
// environment (command source, response sink, decoder tree).
interface gb_host_master_if
    import gb_pkg::*;
#(
    parameter int AW = GB_AW,
    parameter int DW = GB_DW
) ();

    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;

    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_we;
    logic [DW-1:0] rsp_rdata;

    logic [AW-1:0] gb_addr;
    logic [DW-1:0] gb_dout;
    logic          gb_we;
    logic          gb_re;
    logic [DW-1:0] gb_din;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, gb_din,
        output cmd_ready, rsp_valid, rsp_we, rsp_rdata,
               gb_addr, gb_dout, gb_we, gb_re
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, gb_din,
        input  cmd_ready, rsp_valid, rsp_we, rsp_rdata,
               gb_addr, gb_dout, gb_we, gb_re
    );

endinterface

// File: rtl/gb_rsp_fifo.sv
// gb_rsp_fifo: synchronous show-ahead FIFO with asynchronous reset.
//   clk_i, rst_i : clock, async active-high reset (pointers only)
//   push_i, wdata_i : write port
//   pop_i        : consume head entry (ignored when empty)
//   rdata_o      : head entry, forced to 0 while empty
//   empty_o      : no entries stored
// No full flag: users gate pushes with a credit scheme. Push and pop in the
// same cycle are legal even when full, since the popped slot is the one
// being rewritten and its old value is already on rdata_o.
module gb_rsp_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [PW:0]  wr_ptr_q;
    logic [PW:0]  rd_ptr_q;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[PW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i && !empty_o) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q[PW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/gb_host_master.sv
// gb_host_master: ghostbus initiator.
//   gb_clk : bus clock
//   rst    : asynchronous active-high reset
//   bus    : gb_host_master_if.master
//            cmd_*  command stream in (we/addr/wdata)
//            rsp_*  response stream out (we/rdata), strictly in order
//            gb_*   registered root bus; gb_din sampled RD_LAT cycles
//                   after each bus cycle
// Every accepted command becomes one bus cycle and, RD_LAT cycles later,
// one response entry. A credit counter covers both in-flight tags and FIFO
// entries, so the response FIFO can never overflow.
module gb_host_master
    import gb_pkg::*;
#(
    parameter int AW       = GB_AW,
    parameter int DW       = GB_DW,
    parameter int RD_LAT   = GB_RD_LAT,
    parameter int RF_DEPTH = GB_RF_DEPTH
) (
    input  logic              gb_clk,
    input  logic              rst,
    gb_host_master_if.master  bus
);

    localparam int             CW       = $clog2(RF_DEPTH + 1);
    localparam logic [CW-1:0]  FULL_CNT = CW'(RF_DEPTH);

    logic              cmd_hs;
    logic              rsp_hs;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic              rdy_q;
    logic              gb_we_q;
    logic              gb_re_q;
    logic [AW-1:0]     gb_addr_q;
    logic [DW-1:0]     gb_dout_q;
    logic [RD_LAT-1:0] tag_vld_q;
    logic [RD_LAT-1:0] tag_we_q;
    logic              fifo_push;
    logic              fifo_empty;
    logic [DW:0]       fifo_wdata;
    logic [DW:0]       fifo_rdata;

    assign cmd_hs = bus.cmd_valid & rdy_q;
    assign rsp_hs = ~fifo_empty & bus.rsp_ready;

    // Outstanding = tags in flight + entries waiting in the FIFO.
    always_comb begin
        cnt_d = cnt_q;
        case ({cmd_hs, rsp_hs})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge gb_clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            rdy_q     <= 1'b0;
            gb_we_q   <= 1'b0;
            gb_re_q   <= 1'b0;
            gb_addr_q <= '0;
            gb_dout_q <= '0;
            tag_vld_q <= '0;
            tag_we_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            // Registered from the next count so it never depends on cmd_valid.
            rdy_q <= (cnt_d < FULL_CNT);

            // Issue stage: bus outputs for cycle T+1.
            gb_we_q <= cmd_hs & bus.cmd_we;
            gb_re_q <= cmd_hs & ~bus.cmd_we;
            if (cmd_hs) begin
                gb_addr_q <= bus.cmd_addr;
            end
            if (cmd_hs && bus.cmd_we) begin
                gb_dout_q <= bus.cmd_wdata;
            end

            // Tag pipeline: bit 0 is aligned with the bus stage, bit RD_LAT-1
            // with the cycle in which gb_din is valid.
            tag_vld_q <= (tag_vld_q << 1) | RD_LAT'(cmd_hs);
            tag_we_q  <= (tag_we_q << 1) | RD_LAT'(bus.cmd_we);
        end
    end

    // Capture stage: write completions travel the same path as reads.
    assign fifo_push  = tag_vld_q[RD_LAT-1];
    assign fifo_wdata = {tag_we_q[RD_LAT-1],
                         tag_we_q[RD_LAT-1] ? {DW{1'b0}} : bus.gb_din};

    gb_rsp_fifo #(
        .W     (DW + 1),
        .DEPTH (RF_DEPTH)
    ) u_rsp_fifo (
        .clk_i   (gb_clk),
        .rst_i   (rst),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (rsp_hs),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty)
    );

    assign bus.cmd_ready = rdy_q;
    assign bus.rsp_valid = ~fifo_empty;
    assign bus.rsp_we    = fifo_rdata[DW];
    assign bus.rsp_rdata = fifo_rdata[DW-1:0];
    assign bus.gb_addr   = gb_addr_q;
    assign bus.gb_dout   = gb_dout_q;
    assign bus.gb_we     = gb_we_q;
    assign bus.gb_re     = gb_re_q;

endmodule

// File: tb/tb_gb_host_master.sv
// Testbench for gb_host_master: dut0 uses RD_LAT=1/RF_DEPTH=4, dut1 uses
// RD_LAT=3/RF_DEPTH=8. Each has a memory responder and an in-order
// response scoreboard fed from a reference memory.
module tb_gb_host_master;
    import gb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        cv [2];
    logic        cw [2];
    logic [23:0] ca [2];
    logic [31:0] cd [2];
    logic        rr [2];
    logic        cr [2];
    logic        rv [2];
    logic        rwe [2];
    logic [31:0] rrd [2];
    logic [23:0] gaddr [2];
    logic [31:0] gdout [2];
    logic        gwe [2];
    logic        gre [2];
    logic [31:0] gdin [2];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int stalls = 0;

    always @(posedge clk) cyc <= cyc + 1;

    gb_host_master_if #(.AW(24), .DW(32)) bif0 ();
    gb_host_master_if #(.AW(24), .DW(32)) bif1 ();

`define CONN(IFN, I) \
    assign IFN.cmd_valid = cv[I]; \
    assign IFN.cmd_we    = cw[I]; \
    assign IFN.cmd_addr  = ca[I]; \
    assign IFN.cmd_wdata = cd[I]; \
    assign IFN.rsp_ready = rr[I]; \
    assign IFN.gb_din    = gdin[I]; \
    assign cr[I]    = IFN.cmd_ready; \
    assign rv[I]    = IFN.rsp_valid; \
    assign rwe[I]   = IFN.rsp_we; \
    assign rrd[I]   = IFN.rsp_rdata; \
    assign gaddr[I] = IFN.gb_addr; \
    assign gdout[I] = IFN.gb_dout; \
    assign gwe[I]   = IFN.gb_we; \
    assign gre[I]   = IFN.gb_re;

    `CONN(bif0, 0)
    `CONN(bif1, 1)

    gb_host_master #(.AW(24), .DW(32), .RD_LAT(1), .RF_DEPTH(4)) dut0 (
        .gb_clk (clk),
        .rst    (rst),
        .bus    (bif0.master)
    );

    gb_host_master #(.AW(24), .DW(32), .RD_LAT(3), .RF_DEPTH(8)) dut1 (
        .gb_clk (clk),
        .rst    (rst),
        .bus    (bif1.master)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    for (genvar g = 0; g < 2; g++) begin : mon
        localparam int LAT = (g == 0) ? 1 : 3;
        gb_rsp_t     sb [$];
        logic [31:0] model [256];
        logic [31:0] rmem [256];
        logic [31:0] dly0;
        logic [31:0] dly1;
        int          nrsp = 0;
        int          maxq = 0;
        int          rcyc [$];

        initial begin
            for (int i = 0; i < 256; i++) begin
                model[i] = 32'hA500_0000 + i;
                rmem[i]  = 32'hA500_0000 + i;
            end
        end

        // Responder: memory indexed by gb_addr[7:0], read data valid
        // LAT cycles after the bus cycle (same cycle when LAT=1).
        always @(posedge clk) begin
            if (gwe[g]) rmem[gaddr[g][7:0]] <= gdout[g];
            dly0 <= rmem[gaddr[g][7:0]];
            dly1 <= dly0;
        end
        assign gdin[g] = (LAT == 1) ? rmem[gaddr[g][7:0]] : dly1;

        // Scoreboard: handshakes are sampled mid-cycle.
        always @(negedge clk) begin
            gb_rsp_t e;
            if (rst) begin
                sb.delete();
            end else begin
                if (rv[g] && rr[g]) begin
                    if (sb.size() == 0) e = '{we: 1'b1, rdata: 32'hDEAD_BEEF};
                    else e = sb.pop_front();
                    chk($sformatf("rsp%0d_%0d", g, nrsp), {30'b0, rwe[g], rrd[g]}, {31'b0, e});
                    nrsp++;
                    rcyc.push_back(cyc);
                end
                if (cv[g] && cr[g]) begin
                    e.we    = cw[g];
                    e.rdata = cw[g] ? 32'h0 : model[ca[g][7:0]];
                    if (cw[g]) model[ca[g][7:0]] = cd[g];
                    sb.push_back(e);
                    if (sb.size() > maxq) maxq = sb.size();
                end
            end
        end
    end

    task automatic send(input int d, input logic we, input logic [23:0] a, input logic [31:0] wd);
        int n;
        n = 0;
        cv[d] = 1'b1;
        cw[d] = we;
        ca[d] = a;
        cd[d] = wd;
        while (!cr[d] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        stalls += n;
        if (n >= 100) begin
            chk($sformatf("send_timeout%0d", d), cr[d], 1);
            cv[d] = 1'b0;
        end else begin
            @(posedge clk); #1;
            cv[d] = 1'b0;
        end
    endtask

    initial begin
        int  mark;
        int  acc;
        logic hs;
        for (int d = 0; d < 2; d++) begin
            cv[d] = 1'b0; cw[d] = 1'b0; ca[d] = '0; cd[d] = '0; rr[d] = 1'b1;
        end
        rst = 1'b1;
        #3;
        chk("rst_bus0", {gwe[0], gre[0], gaddr[0], gdout[0]}, 0);
        chk("rst_rsp0", {cr[0], rv[0], rwe[0], rrd[0]}, 0);
        chk("rst_dut1", {cr[1], rv[1], gwe[1], gre[1], rrd[1]}, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rdy_before_edge", cr[0], 0);
        @(posedge clk); #1;
        chk("rdy_rise", {cr[0], cr[1]}, 2'b11);

        // Single write then read on dut0.
        send(0, 1'b1, 24'h000000, 32'h42);
        chk("wr_bus", {gwe[0], gre[0], gaddr[0], gdout[0]}, {1'b1, 1'b0, 24'h0, 32'h42});
        @(posedge clk); #1;
        chk("wr_pulse_end", {gwe[0], gre[0]}, 2'b00);
        chk("wr_rsp", {rv[0], rwe[0], rrd[0]}, {1'b1, 1'b1, 32'h0});
        send(0, 1'b0, 24'h000000, 32'h0);
        chk("rd_bus", {gwe[0], gre[0], gaddr[0], gdout[0]}, {1'b0, 1'b1, 24'h0, 32'h42});
        @(posedge clk); #1;
        chk("rd_rsp", {gre[0], rv[0], rwe[0], rrd[0]}, {1'b0, 1'b1, 1'b0, 32'h42});
        repeat (3) @(posedge clk); #1;

        // Streaming 16 back-to-back reads.
        stalls = 0;
        mark = mon[0].nrsp;
        for (int i = 0; i < 16; i++) send(0, 1'b0, 24'(32'h40 + i), 32'h0);
        repeat (6) @(posedge clk); #1;
        chk("stream_stalls", stalls, 0);
        chk("stream_count", mon[0].nrsp - mark, 16);
        chk("stream_span", mon[0].rcyc[mark + 15] - mon[0].rcyc[mark], 15);

        // Backpressure: 8 reads offered with rsp_ready low.
        rr[0] = 1'b0;
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            cv[0] = (acc < 8); cw[0] = 1'b0; ca[0] = 24'(32'h10 + acc);
            hs = cv[0] && cr[0];
            @(posedge clk); #1;
            if (hs) acc++;
        end
        chk("bp_accepted", acc, 4);
        chk("bp_ready_low", {cr[0], rv[0]}, 2'b01);
        rr[0] = 1'b1;
        @(posedge clk); #1;
        rr[0] = 1'b0;
        chk("bp_ready_after_pop", cr[0], 1);
        ca[0] = 24'(32'h10 + acc);
        hs = cv[0] && cr[0];
        @(posedge clk); #1;
        if (hs) acc++;
        cv[0] = 1'b0;
        chk("bp_accepted2", acc, 5);
        chk("bp_ready_low2", cr[0], 0);

        // Drain from full while new reads stream in.
        rr[0] = 1'b1;
        for (int i = 0; i < 8; i++) send(0, 1'b0, 24'(32'h50 + i), 32'h0);
        repeat (20) @(posedge clk); #1;
        chk("drain_empty0", mon[0].sb.size(), 0);

        // Reset with three reads in flight.
        send(0, 1'b0, 24'h01, 32'h0);
        send(0, 1'b0, 24'h02, 32'h0);
        send(0, 1'b0, 24'h03, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_bus", {gwe[0], gre[0]}, 2'b00);
        chk("rst_async_rsp", {rv[0], cr[0]}, 2'b00);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        mark = mon[0].nrsp;
        send(0, 1'b0, 24'h000000, 32'h0);
        @(posedge clk); #1;
        chk("post_rst_rd", {rv[0], rwe[0], rrd[0]}, {1'b1, 1'b0, 32'h42});
        repeat (5) @(posedge clk); #1;
        chk("post_rst_count", mon[0].nrsp - mark, 1);

        // RD_LAT=3: latency then interleaved reads and writes.
        send(1, 1'b0, 24'h05, 32'h0);
        @(posedge clk); #1;
        chk("l3_edge2", rv[1], 0);
        @(posedge clk); #1;
        chk("l3_edge3", rv[1], 0);
        @(posedge clk); #1;
        chk("l3_edge4", {rv[1], rwe[1], rrd[1]}, {1'b1, 1'b0, 32'hA500_0005});
        repeat (2) @(posedge clk); #1;
        send(1, 1'b1, 24'h20, 32'h1111_0000);
        send(1, 1'b0, 24'h20, 32'h0);
        send(1, 1'b0, 24'h21, 32'h0);
        send(1, 1'b1, 24'h21, 32'h2222_0000);
        send(1, 1'b0, 24'h21, 32'h0);
        send(1, 1'b0, 24'h20, 32'h0);
        send(1, 1'b1, 24'h22, 32'h3333_0000);
        send(1, 1'b0, 24'h22, 32'h0);
        send(1, 1'b0, 24'h23, 32'h0);
        repeat (12) @(posedge clk); #1;

        chk("sb0_empty", mon[0].sb.size(), 0);
        chk("sb1_empty", mon[1].sb.size(), 0);
        chk("l3_count", mon[1].nrsp, 10);
        chk("credit0", mon[0].maxq <= 4, 1);
        chk("credit1", mon[1].maxq <= 8, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
